// File: rtl/dds_wave_gen.sv
// DDS waveform generator: phase accumulator, address stage, shape stage.
// Define WAVE_SWITCH_SYNC_EN to latch wave_select only on phase wrap.
module dds_wave_gen #(
  parameter logic [31:0] FREQ_CTRL  = 32'd42949,
  parameter logic [11:0] PHASE_CTRL = 12'd0
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] wave_select,
  output logic [7:0] dac_data,
  output logic       phase_wrap
);

  logic [31:0] fre_add_q;
  logic [31:0] fre_add_d;
  logic        wrap_q;
  logic        wrap_d;
  logic [11:0] rom_addr_q;
  logic [11:0] rom_addr_d;
  logic [3:0]  wave_active_q;
  logic [3:0]  wave_active_d;
  logic [7:0]  dac_q;
  logic [7:0]  dac_d;
  logic [32:0] acc_sum;
  logic [5:0]  sin_idx;
  logic [6:0]  sin_t;
  logic        unused_lsb;

  assign acc_sum    = {1'b0, fre_add_q} + {1'b0, FREQ_CTRL};
  assign fre_add_d  = acc_sum[31:0];
  assign wrap_d     = acc_sum[32];
  assign rom_addr_d = fre_add_q[31:20] + PHASE_CTRL;
  assign unused_lsb = ^rom_addr_q[2:0];

`ifdef WAVE_SWITCH_SYNC_EN
  assign wave_active_d = wrap_q ? wave_select : wave_active_q;
`else
  assign wave_active_d = wave_select;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fre_add_q     <= '0;
      wrap_q        <= 1'b0;
      rom_addr_q    <= '0;
      wave_active_q <= 4'b0000;
      dac_q         <= 8'd128;
    end else begin
      fre_add_q     <= fre_add_d;
      wrap_q        <= wrap_d;
      rom_addr_q    <= rom_addr_d;
      wave_active_q <= wave_active_d;
      dac_q         <= dac_d;
    end
  end

  // odd quadrants walk the quarter-wave table backwards
  assign sin_idx = rom_addr_q[10] ? ~rom_addr_q[9:4] : rom_addr_q[9:4];

  always_comb begin
    sin_t = '0;
    case (sin_idx)
      6'd0:  sin_t = 7'd2;
      6'd1:  sin_t = 7'd5;
      6'd2:  sin_t = 7'd8;
      6'd3:  sin_t = 7'd11;
      6'd4:  sin_t = 7'd14;
      6'd5:  sin_t = 7'd17;
      6'd6:  sin_t = 7'd20;
      6'd7:  sin_t = 7'd23;
      6'd8:  sin_t = 7'd26;
      6'd9:  sin_t = 7'd29;
      6'd10: sin_t = 7'd32;
      6'd11: sin_t = 7'd35;
      6'd12: sin_t = 7'd38;
      6'd13: sin_t = 7'd41;
      6'd14: sin_t = 7'd44;
      6'd15: sin_t = 7'd47;
      6'd16: sin_t = 7'd50;
      6'd17: sin_t = 7'd53;
      6'd18: sin_t = 7'd56;
      6'd19: sin_t = 7'd58;
      6'd20: sin_t = 7'd61;
      6'd21: sin_t = 7'd64;
      6'd22: sin_t = 7'd67;
      6'd23: sin_t = 7'd69;
      6'd24: sin_t = 7'd72;
      6'd25: sin_t = 7'd74;
      6'd26: sin_t = 7'd77;
      6'd27: sin_t = 7'd79;
      6'd28: sin_t = 7'd82;
      6'd29: sin_t = 7'd84;
      6'd30: sin_t = 7'd86;
      6'd31: sin_t = 7'd89;
      6'd32: sin_t = 7'd91;
      6'd33: sin_t = 7'd93;
      6'd34: sin_t = 7'd95;
      6'd35: sin_t = 7'd97;
      6'd36: sin_t = 7'd99;
      6'd37: sin_t = 7'd101;
      6'd38: sin_t = 7'd103;
      6'd39: sin_t = 7'd105;
      6'd40: sin_t = 7'd106;
      6'd41: sin_t = 7'd108;
      6'd42: sin_t = 7'd110;
      6'd43: sin_t = 7'd111;
      6'd44: sin_t = 7'd113;
      6'd45: sin_t = 7'd114;
      6'd46: sin_t = 7'd115;
      6'd47: sin_t = 7'd117;
      6'd48: sin_t = 7'd118;
      6'd49: sin_t = 7'd119;
      6'd50: sin_t = 7'd120;
      6'd51: sin_t = 7'd121;
      6'd52: sin_t = 7'd122;
      6'd53: sin_t = 7'd123;
      6'd54: sin_t = 7'd124;
      6'd55: sin_t = 7'd124;
      6'd56: sin_t = 7'd125;
      6'd57: sin_t = 7'd125;
      6'd58: sin_t = 7'd126;
      6'd59: sin_t = 7'd126;
      6'd60: sin_t = 7'd127;
      6'd61: sin_t = 7'd127;
      6'd62: sin_t = 7'd127;
      6'd63: sin_t = 7'd127;
      default: sin_t = '0;
    endcase
  end

  // non-one-hot codes park the output at mid-scale
  always_comb begin
    dac_d = 8'd128;
    case (wave_active_q)
      4'b0001: dac_d = rom_addr_q[11] ? 8'd127 - {1'b0, sin_t}
                                      : 8'd128 + {1'b0, sin_t};
      4'b0010: dac_d = rom_addr_q[11] ? 8'd0 : 8'd255;
      4'b0100: dac_d = rom_addr_q[11] ? ~rom_addr_q[10:3]
                                      : rom_addr_q[10:3];
      4'b1000: dac_d = rom_addr_q[11:4];
      default: dac_d = 8'd128;
    endcase
  end

  assign dac_data   = dac_q;
  assign phase_wrap = wrap_q;

endmodule
